// File: rtl/merge_sort_pkg.sv
// merge_sort_pkg: shared constants for the streaming merge sorter.
//   ST_*      : controller state encoding (LOAD -> SORT -> OUTPUT -> LOAD)
//   SORT_*    : sort-order encoding of the sampled 'descending' input
package merge_sort_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD   = 2'd0;
    localparam state_t ST_SORT   = 2'd1;
    localparam state_t ST_OUTPUT = 2'd2;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

endpackage

// File: rtl/merge_sel.sv
// merge_sel: combinational merge-step chooser.
//   left_i/right_i           : heads of the left and right runs
//   left_done_i/right_done_i : run exhausted flags
//   mode_i                   : SORT_ASC / SORT_DESC
//   take_left_o              : 1 = consume the left head this step
// Ties go to the left run, which keeps the merge sort stable.
module merge_sel
    import merge_sort_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] left_i,
    input  logic [WIDTH-1:0] right_i,
    input  logic             left_done_i,
    input  logic             right_done_i,
    input  logic             mode_i,
    output logic             take_left_o
);

    always_comb begin
        if (right_done_i)             take_left_o = 1'b1;
        else if (left_done_i)         take_left_o = 1'b0;
        else if (mode_i == SORT_DESC) take_left_o = (left_i >= right_i);
        else                          take_left_o = (left_i <= right_i);
    end

endmodule

// File: rtl/merge_sort_stream.sv
// merge_sort_stream: loads N = 2**LOG_N words, sorts them with bottom-up
// merge sort across two ping-pong buffers (one element written per cycle),
// then streams the result out.
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_data, descending : job input stream + order select
//   out_valid/out_ready/out_data/out_last : sorted output stream
//   busy                                  : high during SORT and OUTPUT
module merge_sort_stream
    import merge_sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             descending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int N  = 1 << LOG_N;
    localparam int CW = LOG_N + 1;
    localparam int PW = $clog2(LOG_N) + 1;
    // Pass 0 writes bufB, so an odd pass count leaves the result in bufB.
    localparam bit FIN_B = (LOG_N % 2) == 1;
    localparam logic [CW-1:0] LAST      = CW'(N - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(LOG_N - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q, li_q, ri_q;
    logic [PW-1:0]    pass_q;
    logic             mode_q, in_ready_q, out_valid_q, out_last_q, busy_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] bufa_q [N];
    logic [WIDTH-1:0] bufb_q [N];

    logic [CW-1:0]    run_len, pair_base;
    logic [LOG_N-1:0] l_addr, r_addr, w_addr, rd_addr_nxt;
    logic [WIDTH-1:0] l_val, r_val, w_val, fin_nxt;
    logic             l_done, r_done, take_left, src_is_b;
    logic             load_fire, out_fire, cnt_last, pair_end;

    // cnt_q is the write index in SORT, so it also locates the current run pair.
    assign run_len   = CW'(1) << pass_q;
    assign pair_base = cnt_q & ~((run_len << 1) - CW'(1));
    // When the right run is exhausted r_addr may wrap; the value is unused then.
    assign l_addr    = LOG_N'(pair_base + li_q);
    assign r_addr    = LOG_N'(pair_base + run_len + ri_q);
    assign w_addr    = cnt_q[LOG_N-1:0];
    assign src_is_b  = pass_q[0];
    assign l_val     = src_is_b ? bufb_q[l_addr] : bufa_q[l_addr];
    assign r_val     = src_is_b ? bufb_q[r_addr] : bufa_q[r_addr];
    assign l_done    = (li_q == run_len);
    assign r_done    = (ri_q == run_len);
    assign w_val     = take_left ? l_val : r_val;
    assign pair_end  = (li_q + ri_q + CW'(1)) == (run_len << 1);
    assign cnt_last  = (cnt_q == LAST);

    // One read port on the final buffer: at the end of SORT cnt_q is N-1,
    // so cnt_q+1 wraps to element 0, which is exactly the first output beat.
    assign rd_addr_nxt = LOG_N'(cnt_q + CW'(1));
    assign fin_nxt     = FIN_B ? bufb_q[rd_addr_nxt] : bufa_q[rd_addr_nxt];

    assign load_fire = (state_q == ST_LOAD) && in_ready_q && in_valid;
    assign out_fire  = (state_q == ST_OUTPUT) && out_valid_q && out_ready;

    merge_sel #(.WIDTH(WIDTH)) u_sel (
        .left_i      (l_val),
        .right_i     (r_val),
        .left_done_i (l_done),
        .right_done_i(r_done),
        .mode_i      (mode_q),
        .take_left_o (take_left)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            li_q        <= '0;
            ri_q        <= '0;
            pass_q      <= '0;
            mode_q      <= SORT_ASC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (load_fire) begin
                        if (cnt_q == '0) mode_q <= descending;
                        if (cnt_last) begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_SORT;
                            cnt_q      <= '0;
                            pass_q     <= '0;
                            li_q       <= '0;
                            ri_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (pair_end) begin
                        li_q <= '0;
                        ri_q <= '0;
                    end else if (take_left) begin
                        li_q <= li_q + CW'(1);
                    end else begin
                        ri_q <= ri_q + CW'(1);
                    end
                    if (cnt_last) begin
                        if (pass_q == LAST_PASS) begin
                            state_q     <= ST_OUTPUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= fin_nxt;
                            out_last_q  <= 1'b0;
                        end else begin
                            pass_q <= pass_q + PW'(1);
                        end
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_LOAD;
                            cnt_q       <= '0;
                            pass_q      <= '0;
                        end else begin
                            cnt_q      <= cnt_q + CW'(1);
                            out_data_q <= fin_nxt;
                            out_last_q <= (cnt_q + CW'(1)) == LAST;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    // Buffers carry no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (load_fire) bufa_q[w_addr] <= in_data;
        if (state_q == ST_SORT) begin
            if (src_is_b) bufa_q[w_addr] <= w_val;
            else          bufb_q[w_addr] <= w_val;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_merge_sort_stream.sv
// tb_merge_sort_stream: directed checks of merge_sort_stream on three
// instances (8b/N=8, 12b/N=2, 12b/N=32) sharing one driver selected by 'sel'.
module tb_merge_sort_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0]  sel = 2'd0;
    logic        in_valid = 1'b0, descending = 1'b0, out_ready = 1'b0;
    logic [11:0] in_data = '0;
    logic [2:0]  ir, ov, ol, bs;
    logic [7:0]  od0;
    logic [11:0] od1, od2;
    logic        m_ir, m_ov, m_ol, m_bs;
    logic [11:0] m_od;

    logic [11:0] din  [32];
    logic [11:0] dexp [32];

    merge_sort_stream #(.WIDTH(8), .LOG_N(3)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd0), .in_ready(ir[0]),
        .in_data(in_data[7:0]), .descending(descending), .out_valid(ov[0]),
        .out_ready(out_ready && sel == 2'd0), .out_data(od0), .out_last(ol[0]), .busy(bs[0]));

    merge_sort_stream #(.WIDTH(12), .LOG_N(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd1), .in_ready(ir[1]),
        .in_data(in_data), .descending(descending), .out_valid(ov[1]),
        .out_ready(out_ready && sel == 2'd1), .out_data(od1), .out_last(ol[1]), .busy(bs[1]));

    merge_sort_stream #(.WIDTH(12), .LOG_N(5)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel == 2'd2), .in_ready(ir[2]),
        .in_data(in_data), .descending(descending), .out_valid(ov[2]),
        .out_ready(out_ready && sel == 2'd2), .out_data(od2), .out_last(ol[2]), .busy(bs[2]));

    always_comb begin
        m_ir = ir[sel];
        m_ov = ov[sel];
        m_ol = ol[sel];
        m_bs = bs[sel];
        m_od = (sel == 2'd0) ? {4'h0, od0} : (sel == 2'd1) ? od1 : od2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [11:0] d [8], input logic [11:0] e [8]);
        for (int k = 0; k < 8; k++) begin
            din[k]  = d[k];
            dexp[k] = e[k];
        end
    endtask

    // Reference stable insertion sort (strict compare never moves equal keys).
    task automatic model_sort(input int n, input logic desc);
        logic [11:0] key;
        int j;
        for (int i = 0; i < n; i++) dexp[i] = din[i];
        for (int i = 1; i < n; i++) begin
            key = dexp[i];
            j = i - 1;
            while (j >= 0 && (desc ? (dexp[j] < key) : (dexp[j] > key))) begin
                dexp[j+1] = dexp[j];
                j--;
            end
            dexp[j+1] = key;
        end
    endtask

    // Feeds din[0..n-1]; 'descending' is inverted after beat 0 to show it is
    // only sampled once. Leaves in_valid high with junk to probe in_ready=0.
    task automatic load_job(input int n, input logic desc, input bit gaps,
                            input string nm, output int acc);
        int t;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid   = 1'b1;
            in_data    = din[k];
            descending = (k == 0) ? desc : ~desc;
            t = 0;
            while (!m_ir && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk({nm, " in_ready timeout"}, 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        acc     = cyc;
        in_data = 12'h5A5;
    endtask

    task automatic drain_job(input int n, input int lg, input bit bp,
                             input string nm, input int acc);
        int t, i;
        bit stalled;
        logic [11:0] held;
        t = 0;
        while (!m_ov && t < 2000) begin
            chk({nm, " in_ready low in sort"}, m_ir, 0);
            chk({nm, " busy in sort"}, m_bs, 1);
            @(negedge clk);
            t++;
        end
        chk({nm, " sort latency"}, cyc - acc, n * lg);
        i = 0; t = 0; stalled = 0; held = '0;
        while (i < n && t < 4 * n + 10) begin
            out_ready = bp ? ((t % 2) == 0) : 1'b1;
            if (stalled) begin
                chk({nm, " valid held"}, m_ov, 1);
                chk({nm, " data stable"}, m_od, held);
            end
            chk({nm, " in_ready low in output"}, m_ir, 0);
            if (m_ov && out_ready) begin
                chk({nm, " data"}, m_od, dexp[i]);
                chk({nm, " last"}, m_ol, (i == n - 1));
                i++;
                stalled = 0;
            end else begin
                stalled = m_ov;
                held = m_od;
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, " beat count"}, i, n);
        chk({nm, " valid drops"}, m_ov, 0);
        chk({nm, " busy clears"}, m_bs, 0);
        chk({nm, " in_ready back"}, m_ir, 1);
    endtask

    task automatic run_job(input int n, input int lg, input logic desc,
                           input bit gaps, input bit bp, input string nm);
        int acc;
        load_job(n, desc, gaps, nm, acc);
        drain_job(n, lg, bp, nm, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        chk("reset in_ready", m_ir, 0);
        chk("reset out_valid", m_ov, 0);
        chk("reset out_last", m_ol, 0);
        chk("reset out_data", m_od, 0);
        chk("reset busy", m_bs, 0);
        reset = 1'b0;
        chk("in_ready before edge", m_ir, 0);
        @(negedge clk);
        chk("in_ready after edge", m_ir, 1);

        // 1: reverse order, ascending
        set_vec('{7, 6, 5, 4, 3, 2, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7});
        run_job(8, 3, 1'b0, 0, 0, "t1");

        // 2: descending with ties
        set_vec('{5, 3, 5, 1, 9, 3, 0, 9}, '{9, 9, 5, 5, 3, 3, 1, 0});
        run_job(8, 3, 1'b1, 0, 0, "t2");

        // 3: unsigned extremes, then all-equal
        set_vec('{'hFF, 'h00, 'hFF, 'h00, 'h80, 'h7F, 'h80, 'h7F},
                '{'h00, 'h00, 'h7F, 'h7F, 'h80, 'h80, 'hFF, 'hFF});
        run_job(8, 3, 1'b0, 0, 0, "t3a");
        set_vec('{'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA},
                '{'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA});
        run_job(8, 3, 1'b0, 0, 0, "t3b");

        // 4: input gaps and output backpressure
        set_vec('{7, 6, 5, 4, 3, 2, 1, 0}, '{0, 1, 2, 3, 4, 5, 6, 7});
        run_job(8, 3, 1'b0, 1, 1, "t4");

        // 5: reset in pass 1, then a fresh job
        set_vec('{'hEE, 'hDD, 'hCC, 'hBB, 'hAA, 'h99, 'h88, 'h77},
                '{'h77, 'h88, 'h99, 'hAA, 'hBB, 'hCC, 'hDD, 'hEE});
        load_job(8, 1'b0, 0, "t5", acc);
        repeat (11) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5 reset out_valid", m_ov, 0);
        chk("t5 reset in_ready", m_ir, 0);
        chk("t5 reset busy", m_bs, 0);
        chk("t5 reset out_data", m_od, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("t5 in_ready before edge", m_ir, 0);
        @(negedge clk);
        chk("t5 in_ready after edge", m_ir, 1);
        set_vec('{3, 1, 2, 0, 7, 5, 6, 4}, '{0, 1, 2, 3, 4, 5, 6, 7});
        run_job(8, 3, 1'b0, 0, 0, "t5");

        // 6: N=2 and N=32 sweeps against the reference sort
        sel = 2'd1;
        for (int j = 0; j < 20; j++) begin
            din[0] = 12'($urandom_range(0, 4095));
            din[1] = (j % 3 == 0) ? din[0] : 12'($urandom_range(0, 4095));
            model_sort(2, j[0]);
            run_job(2, 1, j[0], j[1], j[2], "t6n2");
        end
        sel = 2'd2;
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < 32; k++)
                din[k] = j[1] ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 15));
            model_sort(32, j[0]);
            run_job(32, 5, j[0], j[2], j[1], "t6n32");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
